// File: rtl/crc32_arbiter_if.sv
// crc32_arbiter_if
//   Link between crc32_arbiter and the bit-serial crc32 engine.
//   master : arbiter side, drives start/seed-load/data/orientation.
//   slave  : engine side, returns ready and the accumulator.
//   Signals:
//     crc_start    - launch one 32-bit serial pass on crc_data_in
//     crc_reset    - load crc_data_in into the engine accumulator (seed)
//     crc_data_in  - seed or data word
//     crc_orient   - polynomial / orientation mask
//     crc_ready    - engine idle
//     crc_data_out - engine accumulator
interface crc32_arbiter_if;
    logic        crc_start;
    logic        crc_reset;
    logic [31:0] crc_data_in;
    logic [31:0] crc_orient;
    logic        crc_ready;
    logic [31:0] crc_data_out;

    modport master (
        output crc_start, crc_reset, crc_data_in, crc_orient,
        input  crc_ready, crc_data_out
    );

    modport slave (
        input  crc_start, crc_reset, crc_data_in, crc_orient,
        output crc_ready, crc_data_out
    );
endinterface

// File: rtl/crc32_arbiter.sv
// crc32_arbiter
//   Round-robin arbiter + sequencer sharing one bit-serial crc32 engine among
//   NREQ requesters. The owner's seed is loaded, then each message word is
//   started on the engine and its 32-cycle pass waited out; the final
//   accumulator is returned on a valid/ready result port.
//
//   Ports:
//     CLK, nRST             - clock, asynchronous active-low reset
//     req_valid/data/last   - per-requester word stream (slice i = [32*i +: 32])
//     req_seed/req_poly     - per-requester seed and polynomial mask
//     req_ready             - one-cycle pulse when the owner's word is accepted
//     grant                 - one-hot current owner, zero when idle
//     res_valid/ready       - result handshake
//     res_crc/res_id        - final CRC and owning requester index
//     eng                   - engine port (crc32_arbiter_if.master)
//
//   Build option: CRC32_ARB_XOROUT_EN defined -> res_crc is the accumulator
//   inverted at capture; undefined -> accumulator passed through unchanged.
module crc32_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*32-1:0] req_seed,
    input  logic [NREQ*32-1:0] req_poly,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    grant,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_crc,
    output logic [IDW-1:0]     res_id,
    crc32_arbiter_if.master    eng
);

`ifdef CRC32_ARB_XOROUT_EN
    localparam logic [31:0] XOROUT = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] XOROUT = 32'h0000_0000;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_FEED, S_BUSY, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] g_q, g_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic           last_q, last_d;
    logic [31:0]    res_crc_q, res_crc_d;

    logic [31:0]    seed_g, data_g, poly_g;
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic           granted;

    assign seed_g = req_seed[int'(g_q)*32 +: 32];
    assign data_g = req_data[int'(g_q)*32 +: 32];
    assign poly_g = req_poly[int'(g_q)*32 +: 32];

    // First valid requester at or above rr_q, wrapping modulo NREQ.
    always_comb begin
        int j;
        win_idx   = '0;
        win_found = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!win_found && req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            rr_q      <= '0;
            res_id_q  <= '0;
            last_q    <= 1'b0;
            res_crc_q <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            rr_q      <= rr_d;
            res_id_q  <= res_id_d;
            last_q    <= last_d;
            res_crc_q <= res_crc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        rr_d      = rr_q;
        res_id_d  = res_id_q;
        last_d    = last_q;
        res_crc_d = res_crc_q;
        case (state_q)
            S_IDLE: if (win_found) begin
                g_d     = win_idx;
                state_d = S_SEED;
            end
            S_SEED: state_d = S_FEED;
            S_FEED: if (req_valid[g_q] && eng.crc_ready) begin
                last_d  = req_last[g_q];
                state_d = S_BUSY;
            end
            // crc_ready is registered in the engine, so it is already low
            // on the first BUSY cycle after a start.
            S_BUSY: if (eng.crc_ready) begin
                if (last_q) begin
                    res_crc_d = eng.crc_data_out ^ XOROUT;
                    res_id_d  = g_q;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_FEED;
                end
            end
            S_DONE: if (res_ready) begin
                rr_d    = (int'(g_q) == NREQ-1) ? '0 : g_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        granted         = (state_q != S_IDLE);
        req_ready       = '0;
        grant           = '0;
        res_valid       = (state_q == S_DONE);
        eng.crc_start   = 1'b0;
        eng.crc_reset   = 1'b0;
        eng.crc_data_in = '0;
        eng.crc_orient  = '0;
        if (granted) begin
            grant[g_q]     = 1'b1;
            eng.crc_orient = poly_g;
        end
        case (state_q)
            S_SEED: begin
                eng.crc_reset   = 1'b1;
                eng.crc_data_in = seed_g;
            end
            S_FEED: begin
                eng.crc_data_in = data_g;
                if (req_valid[g_q] && eng.crc_ready) begin
                    eng.crc_start  = 1'b1;
                    req_ready[g_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign res_crc = res_crc_q;
    assign res_id  = res_id_q;

endmodule

// File: tb/tb_crc32_arbiter.sv
// tb_crc32_arbiter
//   Bench for crc32_arbiter with a behavioural bit-serial engine. Table of
//   message vectors plus hand-written reset, backpressure and round-robin
//   sequences. Expected CRCs go to a scoreboard when a message is queued and
//   are compared when the result handshake completes.
module tb_crc32_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef CRC32_ARB_XOROUT_EN
    localparam logic [31:0] XOROUT = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] XOROUT = 32'h0000_0000;
`endif

    logic CLK  = 1'b0;
    logic nRST = 1'b1;
    always #5 CLK = ~CLK;

    logic [NREQ-1:0]    req_valid = '0, req_last = '0;
    logic [NREQ*32-1:0] req_data = '0, req_seed = '0, req_poly = '0;
    logic [NREQ-1:0]    req_ready, grant;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic [31:0]        res_crc;
    logic [IDW-1:0]     res_id;

    crc32_arbiter_if eif ();

    crc32_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_seed(req_seed), .req_poly(req_poly), .req_ready(req_ready),
        .grant(grant), .res_valid(res_valid), .res_ready(res_ready),
        .res_crc(res_crc), .res_id(res_id), .eng(eif)
    );

    // ---------------- engine model: one bit per clock, MSB first ----------
    logic [31:0] e_acc, e_word, e_poly;
    logic [4:0]  e_cnt;
    logic        e_busy;
    assign eif.crc_ready    = ~e_busy;
    assign eif.crc_data_out = e_acc;

    function automatic logic [31:0] bit_step(input logic [31:0] a, input logic b,
                                             input logic [31:0] p);
        return {a[30:0], 1'b0} ^ (((a[31] ^ b) != 1'b0) ? p : 32'h0);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            e_acc <= '0; e_word <= '0; e_poly <= '0; e_cnt <= '0; e_busy <= 1'b0;
        end else if (e_busy) begin
            e_acc <= bit_step(e_acc, e_word[e_cnt], e_poly);
            if (e_cnt == 5'd0) e_busy <= 1'b0;
            else               e_cnt  <= e_cnt - 5'd1;
        end else if (eif.crc_reset) begin
            e_acc <= eif.crc_data_in;
        end else if (eif.crc_start) begin
            e_acc  <= bit_step(e_acc, eif.crc_data_in[31], eif.crc_orient);
            e_word <= eif.crc_data_in;
            e_poly <= eif.crc_orient;
            e_cnt  <= 5'd30;
            e_busy <= 1'b1;
        end
    end

    // Whole-message reference, computed word by word.
    function automatic logic [31:0] golden(input logic [31:0] seed, input logic [31:0] poly,
                                           input logic [2:0][31:0] w, input int nw);
        logic [31:0] c;
        logic        fb;
        c = seed;
        for (int k = 0; k < nw; k++)
            for (int b = 31; b >= 0; b--) begin
                fb = c[31] ^ w[k][b];
                c  = (c << 1) ^ (fb ? poly : 32'h0);
            end
        return c;
    endfunction

    // ---------------- types ----------------
    typedef struct {
        int              port;
        logic [31:0]     seed;
        logic [31:0]     poly;
        logic [2:0][31:0] w;
        int              nw;
        int              stall;
        int              exp_lat;
    } vec_t;
    typedef struct { logic [31:0] crc; logic [IDW-1:0] id; } exp_t;
    typedef struct { logic [31:0] crc; logic [IDW-1:0] id; int cyc; int rise; } got_t;

    function automatic vec_t mk(input int port, input logic [31:0] seed, poly, w0, w1, w2,
                                input int nw, stall, lat);
        vec_t v;
        v.port = port; v.seed = seed; v.poly = poly; v.w = {w2, w1, w0};
        v.nw = nw; v.stall = stall; v.exp_lat = lat;
        return v;
    endfunction

    // ---------------- monitor ----------------
    int cyc = 0;
    int start_cnt = 0, rrdy_cnt = 0, viol = 0;
    int last_start_cyc = 0, last_reset_cyc = 0, rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic [NREQ-1:0] prev_grant = '0;
    logic [NREQ-1:0] grant_log[$];
    got_t got_q[$];

    initial forever begin
        got_t g;
        @(negedge CLK);
        if (nRST) begin
            if (eif.crc_start) begin start_cnt++; last_start_cyc = cyc; end
            if (eif.crc_reset) last_reset_cyc = cyc;
            if (eif.crc_start && eif.crc_reset) viol++;
            if ((req_ready & ~grant) != '0) viol++;
            if (grant != '0 && !$onehot(grant)) viol++;
            rrdy_cnt += $countones(req_ready);
            if (grant != '0 && grant != prev_grant) grant_log.push_back(grant);
            if (res_valid && !prev_valid) rise_cyc = cyc;
            if (res_valid && res_ready) begin
                g.crc = res_crc; g.id = res_id; g.cyc = cyc; g.rise = rise_cyc;
                got_q.push_back(g);
            end
        end
        prev_grant = grant;
        prev_valid = res_valid;
    end

    // ---------------- driver / checks ----------------
    int n_checks = 0, n_pass = 0;
    int got_rd = 0;
    exp_t sb_q[$];
    logic [32:0] wq[NREQ][$];
    int hold[NREQ];
    int hold_on_pop[NREQ];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (wq[i].size() > 0 && hold[i] == 0) begin
                req_valid[i]        = 1'b1;
                req_data[i*32 +: 32] = wq[i][0][31:0];
                req_last[i]         = wq[i][0][32];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge CLK);
        acc = req_ready;
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && wq[i].size() > 0) begin
                wq[i].delete(0);
                if (hold_on_pop[i] > 0) begin hold[i] = hold_on_pop[i]; hold_on_pop[i] = 0; end
            end else if (hold[i] > 0) begin
                hold[i]--;
            end
        end
        drive();
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NREQ; i++) begin
            wq[i].delete(); hold[i] = 0; hold_on_pop[i] = 0;
        end
        drive();
    endtask

    // stall > 0 holds req_valid low until `stall` cycles into the FEED wait
    // before the second word (32 cycles of BUSY first).
    task automatic send(input vec_t v, input bit push);
        exp_t e;
        req_seed[v.port*32 +: 32] = v.seed;
        req_poly[v.port*32 +: 32] = v.poly;
        for (int k = 0; k < v.nw; k++) wq[v.port].push_back({k == v.nw-1, v.w[k]});
        hold_on_pop[v.port] = (v.stall > 0) ? 32 + v.stall : 0;
        if (push) begin
            e.crc = golden(v.seed, v.poly, v.w, v.nw) ^ XOROUT;
            e.id  = IDW'(v.port);
            sb_q.push_back(e);
        end
        drive();
    endtask

    task automatic wait_result(input string nm, output got_t g);
        int n;
        bit ok;
        n = 0;
        while (got_rd >= got_q.size() && n < 400) begin tick(); n++; end
        ok = (got_rd < got_q.size());
        chk({nm, "_timeout"}, 32'(ok), 32'd1);
        if (ok) begin g = got_q[got_rd]; got_rd++; end
        else begin g.crc = '0; g.id = '0; g.cyc = 0; g.rise = 0; end
    endtask

    task automatic check_sb(input string nm, input got_t g);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_crc"}, g.crc, e.crc);
            chk({nm, "_id"}, 32'(g.id), 32'(e.id));
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({nm, "_grant"}, 32'(grant), 32'd0);
        chk({nm, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({nm, "_res_crc"}, res_crc, 32'd0);
        chk({nm, "_res_id"}, 32'(res_id), 32'd0);
        chk({nm, "_crc_start"}, 32'(eif.crc_start), 32'd0);
        chk({nm, "_crc_reset"}, 32'(eif.crc_reset), 32'd0);
        chk({nm, "_crc_data_in"}, eif.crc_data_in, 32'd0);
        chk({nm, "_crc_orient"}, eif.crc_orient, 32'd0);
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        clear_stim();
        tick(); tick();
        nRST = 1'b1;
    endtask

    // ---------------- test ----------------
    vec_t vecs[4];

    initial begin
        got_t g;
        int c0, s0, r0, gl0, n;
        logic [31:0] crc0;
        bit stable;
        logic [NREQ-1:0] gv;

        vecs[0] = mk(0, 32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h1234_5678, 32'h0, 32'h0, 1, 0, 35);
        vecs[1] = mk(1, 32'hFFFF_FFFF, 32'h04C1_1DB7, 32'hDEAD_BEEF, 32'h0123_4567,
                     32'h89AB_CDEF, 3, 5, 106);
        vecs[2] = mk(3, 32'h0000_0000, 32'hEDB8_8320, 32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h0, 2, 0, 68);
        vecs[3] = mk(2, 32'hA5A5_A5A5, 32'h1EDC_6F41, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, 0, 35);

        clear_stim();
        #2 nRST = 1'b0;
        #1 chk_reset_outs("por");
        tick(); tick();
        nRST = 1'b1;

        // table-driven messages
        for (int i = 0; i < 4; i++) begin
            s0 = start_cnt; r0 = rrdy_cnt; c0 = cyc;
            send(vecs[i], 1'b1);
            wait_result($sformatf("vec%0d", i), g);
            check_sb($sformatf("vec%0d", i), g);
            chk($sformatf("vec%0d_res_cycle", i), 32'(g.cyc - c0), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_valid_rise", i), 32'(g.rise - c0), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_seed_cycle", i), 32'(last_reset_cyc - c0), 32'd1);
            chk($sformatf("vec%0d_last_start", i), 32'(last_start_cyc - c0),
                32'(vecs[i].exp_lat - 33));
            chk($sformatf("vec%0d_starts", i), 32'(start_cnt - s0), 32'(vecs[i].nw));
            chk($sformatf("vec%0d_req_ready", i), 32'(rrdy_cnt - r0), 32'(vecs[i].nw));
        end

        // result backpressure, with a competing request queued on port 0
        res_ready = 1'b0;
        c0 = cyc;
        send(mk(3, 32'h1357_9BDF, 32'h04C1_1DB7, 32'h0F0F_0F0F, 32'h0, 32'h0, 1, 0, 35), 1'b1);
        n = 0;
        while (!res_valid && n < 100) begin tick(); n++; end
        chk("bp_valid_cycle", 32'(cyc - c0), 32'd35);
        crc0 = res_crc;
        send(mk(0, 32'h2468_ACE0, 32'hEDB8_8320, 32'h5555_AAAA, 32'h0, 32'h0, 1, 0, 35), 1'b1);
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (res_valid !== 1'b1 || res_crc !== crc0 || grant !== 4'b1000) stable = 1'b0;
        end
        chk("bp_hold_stable", 32'(stable), 32'd1);
        res_ready = 1'b1;
        wait_result("bp3", g);
        check_sb("bp3", g);
        chk("bp3_accept_cycle", 32'(g.cyc - c0), 32'd45);
        wait_result("bp0", g);
        check_sb("bp0", g);

        // reset in the middle of a serial pass
        send(mk(1, 32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h0000_0001, 32'h0, 32'h0, 1, 0, 35), 1'b0);
        repeat (12) tick();
        chk("mid_busy_granted", 32'(grant), 32'b0010);
        nRST = 1'b0;
        #1 chk_reset_outs("mid_rst");
        clear_stim();
        tick(); tick();
        nRST = 1'b1;
        send(mk(2, 32'hFFFF_FFFF, 32'h04C1_1DB7, 32'hA0B1_C2D3, 32'h0, 32'h0, 1, 0, 35), 1'b1);
        tick();
        chk("post_rst_grant", 32'(grant), 32'b0100);
        chk("post_rst_seed", 32'(eif.crc_reset), 32'd1);
        wait_result("post_rst", g);
        check_sb("post_rst", g);

        // round robin from rr_ptr = 0, all ports requesting
        apply_reset();
        gl0 = grant_log.size();
        for (int p = 0; p < 4; p++)
            send(mk(p, 32'hFFFF_FFFF - 32'(p), 32'h04C1_1DB7, 32'h1111_1111 * 32'(p + 1),
                    32'h0, 32'h0, 1, 0, 35), 1'b1);
        send(mk(0, 32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h7777_0000, 32'h0, 32'h0, 1, 0, 35), 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_result($sformatf("rr%0d", k), g);
            check_sb($sformatf("rr%0d", k), g);
        end
        for (int k = 0; k < 5; k++) begin
            gv = (gl0 + k < grant_log.size()) ? grant_log[gl0 + k] : '0;
            chk($sformatf("rr_grant%0d", k), 32'(gv), 32'(1 << (k % 4)));
        end

        chk("invariants", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
